// File: rtl/cplx_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cplx_acc_pkg
//  Purpose  : Shared constants, phase enum and rounding helper for the
//             complex integrate-and-dump stage.
//  Options  : CPLX_ACC_DUMP_SAT_EN (used by the rail and top modules)
//  Revision : 1.0  initial release
// ============================================================================
package cplx_acc_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_LEN_WIDTH  = 14;

  // ACC: sample folds into the accumulator; DUMP: sample closes the window.
  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DUMP = 1'b1
  } phase_t;

  // Round-half-up constant for an arithmetic right shift of sh bits.
  function automatic logic [31:0] round_const(input logic [4:0] sh);
    round_const = (sh == 5'd0) ? 32'd0 : (32'd1 << (sh - 5'd1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cplx_round_sat.sv
`default_nettype none
// ============================================================================
//  Module   : cplx_round_sat
//  Purpose  : One rail of the dump path: round half up, arithmetic shift,
//             then saturate (CPLX_ACC_DUMP_SAT_EN) or truncate to DATA_WIDTH.
//  Options  : CPLX_ACC_DUMP_SAT_EN
//  Revision : 1.0  initial release
// ============================================================================
module cplx_round_sat
  import cplx_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0]  sum,
  input  logic [4:0]            shift,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  clip
);

  // One guard bit so the rounding add can never wrap.
  logic signed [ACC_WIDTH:0] ext;
  logic signed [ACC_WIDTH:0] rounded;
  logic signed [ACC_WIDTH:0] shifted;

  assign ext     = $signed({sum[ACC_WIDTH-1], sum});
  assign rounded = ext + $signed((ACC_WIDTH+1)'(round_const(shift)));
  assign shifted = rounded >>> shift;

`ifdef CPLX_ACC_DUMP_SAT_EN
  // Value fits when every bit above the output sign bit copies the sign.
  logic [ACC_WIDTH-DATA_WIDTH+1:0] upper;
  logic                            fits;

  assign upper = shifted[ACC_WIDTH:DATA_WIDTH-1];
  assign fits  = (&upper) | (~|upper);
  assign clip  = ~fits;
  assign res   = fits ? shifted[DATA_WIDTH-1:0] :
                 (shifted[ACC_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}});
`else
  // Plain wrap: the upper bits are intentionally dropped.
  logic unused_hi;

  assign unused_hi = ^shifted[ACC_WIDTH:DATA_WIDTH];
  assign res       = shifted[DATA_WIDTH-1:0];
  assign clip      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/cplx_acc_dump.sv
`default_nettype none
// ============================================================================
//  Module   : cplx_acc_dump
//  Purpose  : Complex integrate-and-dump. Accumulates N {I,Q} samples per
//             window and emits one rounded, scaled complex sum per window.
//  Options  : CPLX_ACC_DUMP_SAT_EN enables saturation and the sticky
//             overflow flag; otherwise rails wrap and overflow is 0.
//  Revision : 1.0  initial release
// ============================================================================
module cplx_acc_dump
  import cplx_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic [4:0]              shift,
  input  logic [2*DATA_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
);

  logic [ACC_WIDTH-1:0]  acc_i, acc_q;
  logic [ACC_WIDTH-1:0]  sum_i, sum_q;
  logic [LEN_WIDTH-1:0]  count, len_q, len_eff, n_cur;
  logic [DATA_WIDTH-1:0] res_i, res_q;
  logic                  clip_i, clip_q;
  logic                  last, accept, dump;
  phase_t                phase;

  // A window of 0 behaves as a window of 1.
  assign len_eff = (len == '0) ? LEN_WIDTH'(1) : len;

  // At the start of a window the live len applies; afterwards the latched one.
  assign n_cur  = (count == '0) ? len_eff : len_q;
  assign last   = (count == n_cur - LEN_WIDTH'(1));
  assign phase  = last ? DUMP : ACC;

  // Only the window-closing sample can stall, and only on a full output.
  assign in_ready = ~(last & out_valid & ~out_ready);
  assign accept   = in_valid & in_ready;
  assign dump     = accept & (phase == DUMP);

  assign sum_i = acc_i + {{(ACC_WIDTH-DATA_WIDTH){in_data[2*DATA_WIDTH-1]}},
                          in_data[2*DATA_WIDTH-1:DATA_WIDTH]};
  assign sum_q = acc_q + {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}},
                          in_data[DATA_WIDTH-1:0]};

  cplx_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_rail_i (
    .sum   (sum_i),
    .shift (shift),
    .res   (res_i),
    .clip  (clip_i)
  );

  cplx_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_rail_q (
    .sum   (sum_q),
    .shift (shift),
    .res   (res_q),
    .clip  (clip_q)
  );

  // Window counter, accumulators and single-entry output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_i     <= '0;
      acc_q     <= '0;
      count     <= '0;
      len_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      acc_i     <= '0;
      acc_q     <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        if (count == '0) begin
          len_q <= len_eff;
        end
        if (phase == DUMP) begin
          acc_i    <= '0;
          acc_q    <= '0;
          count    <= '0;
          out_data <= {res_i, res_q};
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          count <= count + LEN_WIDTH'(1);
        end
      end
      if (dump) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CPLX_ACC_DUMP_SAT_EN
  // Sticky clip flag, cleared only by clear or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (dump && (clip_i || clip_q)) begin
      overflow <= 1'b1;
    end
  end
`else
  logic unused_clip;

  assign unused_clip = clip_i | clip_q;
  assign overflow    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cplx_acc_dump.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cplx_acc_dump
//  Purpose  : Self-checking bench for cplx_acc_dump: directed table, corner
//             sequences and randomized traffic against a reference model.
//  Options  : CPLX_ACC_DUMP_SAT_EN selects saturating expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cplx_acc_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [13:0] len;
  logic [4:0]  shift;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: window contents as plain integers.
  longint      m_acc_i, m_acc_q;
  int          m_cnt, m_nwin;
  bit          m_valid, m_ov;
  logic [31:0] m_data;

  typedef struct {
    int          l;
    int          sh;
    logic [15:0] i;
    logic [15:0] q;
    int          n;
    logic [15:0] ei;
    logic [15:0] eq;
    bit          eov;
  } vec_t;

  vec_t tbl[5];

  cplx_acc_dump dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .len       (len),
    .shift     (shift),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_len(input int l);
    return (l == 0) ? 1 : l;
  endfunction

  // Scale a wrapped 32-bit window sum: round half up, shift, clip or wrap.
  function automatic logic [15:0] scale(input longint acc, input int sh, output bit clip);
    longint v;
    logic [15:0] r;
    v = longint'(int'(acc));
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    clip = 1'b0;
`ifdef CPLX_ACC_DUMP_SAT_EN
    if (v > 32767) begin
      r = 16'h7FFF; clip = 1'b1;
    end else if (v < -32768) begin
      r = 16'h8000; clip = 1'b1;
    end else begin
      r = v[15:0];
    end
`else
    r = v[15:0];
`endif
    return r;
  endfunction

  function automatic void model_reset();
    m_acc_i = 0; m_acc_q = 0; m_cnt = 0; m_nwin = 1;
    m_valid = 0; m_ov = 0; m_data = '0;
  endfunction

  // Apply inputs for one cycle, check in_ready, advance the model past the edge.
  task automatic drive(input bit v, input logic [31:0] d, input bit r, input bit c);
    int  n_now;
    bit  rdy, dmp, ci, cq;
    logic [15:0] ri, rq;
    in_valid = v; in_data = d; out_ready = r; clear = c;
    #1;
    n_now = (m_cnt == 0) ? eff_len(int'(len)) : m_nwin;
    rdy   = !((m_cnt == n_now - 1) && m_valid && !r);
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    if (!reset) return;
    if (c) begin
      m_acc_i = 0; m_acc_q = 0; m_cnt = 0; m_valid = 0; m_ov = 0;
      return;
    end
    dmp = 0;
    if (v && rdy) begin
      if (m_cnt == 0) m_nwin = eff_len(int'(len));
      m_acc_i += longint'($signed(d[31:16]));
      m_acc_q += longint'($signed(d[15:0]));
      m_cnt++;
      if (m_cnt == m_nwin) begin
        ri = scale(m_acc_i, int'(shift), ci);
        rq = scale(m_acc_q, int'(shift), cq);
        m_data = {ri, rq};
        m_ov   = m_ov | ci | cq;
        m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
        dmp = 1;
      end
    end
    if (dmp) m_valid = 1;
    else if (m_valid && r) m_valid = 0;
  endtask

  // Step past the next active edge and compare the registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("overflow", {31'd0, overflow}, {31'd0, m_ov});
    if (m_valid) check("out_data", out_data, m_data);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; len = 14'd4; shift = 5'd0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    model_reset();

    // Reset state, including in_ready held high while in reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;

    // Directed window table.
    tbl[0] = '{4, 0, 16'h0001, 16'hFFFF, 4, 16'h0004, 16'hFFFC, 1'b0};
`ifdef CPLX_ACC_DUMP_SAT_EN
    tbl[1] = '{4, 0, 16'h7FFF, 16'h8000, 4, 16'h7FFF, 16'h8000, 1'b1};
`else
    tbl[1] = '{4, 0, 16'h7FFF, 16'h8000, 4, 16'hFFFC, 16'h0000, 1'b0};
`endif
    tbl[2] = '{2, 2, 16'h0003, 16'hFFFD, 2, 16'h0002, 16'hFFFF, 1'b0};
    tbl[3] = '{0, 0, 16'h1234, 16'hABCD, 1, 16'h1234, 16'hABCD, 1'b0};
    tbl[4] = '{3, 1, 16'h0005, 16'h0005, 3, 16'h0008, 16'h0008, 1'b0};

    for (int t = 0; t < 5; t++) begin
      len = 14'(tbl[t].l); shift = 5'(tbl[t].sh);
      drive(0, '0, 1, 1); tick();
      for (int k = 0; k < tbl[t].n; k++) begin
        drive(1, {tbl[t].i, tbl[t].q}, 1, 0); tick();
      end
      check($sformatf("tbl%0d_valid", t), {31'd0, out_valid}, 32'd1);
      check($sformatf("tbl%0d_data", t), out_data, {tbl[t].ei, tbl[t].eq});
      check($sformatf("tbl%0d_ovf", t), {31'd0, overflow}, {31'd0, tbl[t].eov});
      drive(0, '0, 1, 0); tick();
      check($sformatf("tbl%0d_onecycle", t), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: len=2, out_ready low after the first dump.
    begin
      int stalls;
      len = 14'd2; shift = 5'd0;
      drive(0, '0, 1, 1); tick();
      drive(1, {16'd1, 16'd2}, 1, 0); tick();
      drive(1, {16'd3, 16'd4}, 1, 0); tick();
      check("bp_first", out_data, {16'd4, 16'd6});
      drive(1, {16'd10, -16'sd20}, 0, 0);
      check("bp_s3_ready", {31'd0, in_ready}, 32'd1);
      tick();
      stalls = 0;
      for (int k = 0; k < 3; k++) begin
        drive(1, {16'd100, 16'd200}, 0, 0);
        if (!in_ready) stalls++;
        tick();
        check("bp_held", out_data, {16'd4, 16'd6});
      end
      check("bp_stall_cycles", 32'(stalls), 32'd3);
      drive(1, {16'd100, 16'd200}, 1, 0); tick();
      check("bp_second_valid", {31'd0, out_valid}, 32'd1);
      check("bp_second", out_data, {16'd110, 16'd180});
      drive(0, '0, 1, 0); tick();
      check("bp_drained", {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset in the middle of a window.
    len = 14'd4;
    drive(0, '0, 1, 1); tick();
    drive(1, {16'd5, 16'd5}, 1, 0); tick();
    drive(1, {16'd5, 16'd5}, 1, 0); tick();
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", out_data, 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive(0, '0, 1, 0); tick();
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1, {16'd1, 16'd1}, 1, 0); tick();
    end
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_data", out_data, {16'd4, 16'd4});

    // Clear mid-window with a live sample, then a shorter window.
    len = 14'd4;
    drive(0, '0, 1, 1); tick();
    drive(1, {16'd2, 16'd2}, 1, 0); tick();
    drive(1, {16'd2, 16'd2}, 1, 0); tick();
    drive(1, {16'd50, 16'd50}, 1, 1); tick();
    len = 14'd3;
    drive(1, {16'd1, 16'd2}, 1, 0); tick();
    check("clr_no_dump1", {31'd0, out_valid}, 32'd0);
    drive(1, {16'd3, 16'd4}, 1, 0); tick();
    check("clr_no_dump2", {31'd0, out_valid}, 32'd0);
    drive(1, {16'd5, 16'd6}, 1, 0); tick();
    check("clr_dump3", {31'd0, out_valid}, 32'd1);
    check("clr_data", out_data, {16'd9, 16'd12});

    // Randomized traffic against the model.
    drive(0, '0, 1, 1); tick();
    for (int k = 0; k < 600; k++) begin
      logic [31:0] d;
      if ($urandom_range(0, 7) == 0) len = 14'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) shift = 5'($urandom_range(0, 20));
      d = $urandom;
      if ($urandom_range(0, 1) == 0) d = {16'($urandom_range(0, 255)), 16'($urandom_range(0, 255))};
      drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
